// File: rtl/step_dir_generator.sv
// rtl/step_dir_generator.sv - step/dir pulse transmitter with timing guards and position count
//
// Turns accepted move commands into step/dir waveforms for a microstepper
// input. Guarantees dir setup before each step rise, a fixed step high
// time and a minimum step low time, and keeps a signed position count.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   move_valid   command valid
//   move_ready   command accepted when move_valid && move_ready (IDLE only)
//   move_dir     1 = forward (+1), 0 = reverse (-1)
//   move_steps   number of steps to issue
//   move_period  cycles between successive step rising edges
//   abort        stop current move at the next safe point
//   step         step output, active high
//   dir          direction output
//   busy         move in progress
//   done         one-cycle pulse at move end
//   aborted      qualifies done: move ended by abort (held until next accept)
//   position     signed two's complement count of issued steps

module step_dir_generator #(
    parameter int PULSE_WIDTH = 4,
    parameter int DIR_SETUP   = 4,
    parameter int CNT_W       = 16,
    parameter int POS_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             move_valid,
    output logic             move_ready,
    input  logic             move_dir,
    input  logic [CNT_W-1:0] move_steps,
    input  logic [CNT_W-1:0] move_period,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [POS_W-1:0] position
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    // Timers are one bit wider than the period field so period = 2^CNT_W-1
    // never overflows during the low-time arithmetic.
    localparam logic [CNT_W:0]   PW_T     = (CNT_W+1)'(PULSE_WIDTH);
    localparam logic [CNT_W:0]   TWO_PW_T = (CNT_W+1)'(2 * PULSE_WIDTH);
    localparam logic [CNT_W:0]   DS_T     = (CNT_W+1)'(DIR_SETUP);
    localparam logic [CNT_W:0]   ONE_T    = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [POS_W-1:0] ONE_P    = {{(POS_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [CNT_W:0]   timer, timer_nxt;
    logic [CNT_W-1:0] remaining, remaining_nxt;
    logic [CNT_W-1:0] period_q, period_nxt;
    logic             abort_pending, abort_pending_nxt;
    logic             step_nxt, dir_nxt, busy_nxt, done_nxt, aborted_nxt;
    logic             move_ready_nxt;
    logic [POS_W-1:0] position_nxt;
    logic             start_pulse;
    logic [CNT_W:0]   period_ext;
    logic [CNT_W:0]   low_time;

    // Low time L = max(period - PULSE_WIDTH, PULSE_WIDTH); the subtraction
    // only happens when period >= 2*PULSE_WIDTH so it cannot underflow.
    always_comb begin
        period_ext = {1'b0, period_q};
        low_time   = (period_ext >= TWO_PW_T) ? (period_ext - PW_T) : PW_T;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            remaining     <= '0;
            period_q      <= '0;
            abort_pending <= 1'b0;
            step          <= 1'b0;
            dir           <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            position      <= '0;
            move_ready    <= 1'b1;
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            remaining     <= remaining_nxt;
            period_q      <= period_nxt;
            abort_pending <= abort_pending_nxt;
            step          <= step_nxt;
            dir           <= dir_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            aborted       <= aborted_nxt;
            position      <= position_nxt;
            move_ready    <= move_ready_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        timer_nxt         = timer;
        remaining_nxt     = remaining;
        period_nxt        = period_q;
        abort_pending_nxt = abort_pending;
        step_nxt          = step;
        dir_nxt           = dir;
        done_nxt          = 1'b0;
        aborted_nxt       = aborted;
        position_nxt      = position;
        start_pulse       = 1'b0;

        case (state)
            IDLE: begin
                step_nxt          = 1'b0;
                abort_pending_nxt = 1'b0;
                // abort is ignored here; a concurrent command is still taken
                if (move_valid && move_ready) begin
                    aborted_nxt   = 1'b0;
                    period_nxt    = move_period;
                    remaining_nxt = move_steps;
                    if (move_steps == '0) begin
                        done_nxt = 1'b1;
                    end else if (move_dir != dir) begin
                        dir_nxt   = move_dir;
                        state_nxt = SETUP;
                        timer_nxt = DS_T;
                    end else begin
                        state_nxt   = HIGH;
                        start_pulse = 1'b1;
                    end
                end
            end

            SETUP: begin
                if (abort) begin
                    state_nxt   = IDLE;
                    done_nxt    = 1'b1;
                    aborted_nxt = 1'b1;
                end else if (timer <= ONE_T) begin
                    state_nxt   = HIGH;
                    start_pulse = 1'b1;
                end else begin
                    timer_nxt = timer - ONE_T;
                end
            end

            HIGH: begin
                // Never cut a pulse short: remember the abort and shorten
                // only the following low phase to the minimum.
                if (abort) begin
                    abort_pending_nxt = 1'b1;
                end
                if (timer <= ONE_T) begin
                    state_nxt = LOW;
                    step_nxt  = 1'b0;
                    timer_nxt = (abort || abort_pending) ? PW_T : low_time;
                end else begin
                    timer_nxt = timer - ONE_T;
                end
            end

            LOW: begin
                if (abort && !abort_pending) begin
                    state_nxt   = IDLE;
                    done_nxt    = 1'b1;
                    aborted_nxt = 1'b1;
                end else if (timer <= ONE_T) begin
                    if (abort_pending) begin
                        state_nxt   = IDLE;
                        done_nxt    = 1'b1;
                        aborted_nxt = 1'b1;
                    end else if (remaining == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt   = HIGH;
                        start_pulse = 1'b1;
                    end
                end else begin
                    timer_nxt = timer - ONE_T;
                end
            end

            default: begin
                state_nxt = IDLE;
                step_nxt  = 1'b0;
            end
        endcase

        // Common rising-edge bookkeeping: position moves with the step rise.
        if (start_pulse) begin
            step_nxt      = 1'b1;
            timer_nxt     = PW_T;
            remaining_nxt = remaining_nxt - ONE_C;
            position_nxt  = dir_nxt ? (position + ONE_P) : (position - ONE_P);
        end

        busy_nxt       = (state_nxt != IDLE);
        move_ready_nxt = (state_nxt == IDLE) && !done_nxt;
    end

endmodule

// File: tb/tb_step_dir_generator.sv
// tb/tb_step_dir_generator.sv - directed self-checking bench for step_dir_generator

module tb_step_dir_generator;

    logic        clk;
    logic        reset;
    logic        move_valid;
    logic        move_ready;
    logic        move_dir;
    logic [15:0] move_steps;
    logic [15:0] move_period;
    logic        abort;
    logic        step;
    logic        dir;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] position;

    int checks;
    int failures;
    int n;

    step_dir_generator #(
        .PULSE_WIDTH(4),
        .DIR_SETUP  (4),
        .CNT_W      (16),
        .POS_W      (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move_dir   (move_dir),
        .move_steps (move_steps),
        .move_period(move_period),
        .abort      (abort),
        .step       (step),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .position   (position)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle at a time (sampling 1 time unit after the edge) until
    // the selected output reaches val; cnt is the cycle count, -1 on timeout.
    task automatic wait_until(input int which, input logic val, input int budget, output int cnt);
        logic hit;
        hit = 1'b0;
        cnt = 0;
        while (!hit && cnt < budget) begin
            @(posedge clk);
            #1;
            cnt++;
            if (which == 0) hit = (step === val);
            else            hit = (done === val);
        end
        if (!hit) cnt = -1;
    endtask

    // Present a command for exactly one edge; afterwards the bench observes
    // the first cycle after the accept edge.
    task automatic issue(input logic d, input logic [15:0] s, input logic [15:0] p);
        check("ready_before_issue", {31'd0, move_ready}, 32'd1);
        move_valid  = 1'b1;
        move_dir    = d;
        move_steps  = s;
        move_period = p;
        @(posedge clk);
        #1;
        move_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        move_valid  = 1'b0;
        move_dir    = 1'b0;
        move_steps  = '0;
        move_period = '0;
        abort       = 1'b0;

        // Reset state
        #2;
        check("rst_step", {31'd0, step}, 32'd0);
        check("rst_dir", {31'd0, dir}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_aborted", {31'd0, aborted}, 32'd0);
        check("rst_position", position, 32'd0);
        check("rst_ready", {31'd0, move_ready}, 32'd1);
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Forward with dir change: steps=3 period=10 -> setup 4, high 4, low 6
        issue(1'b1, 16'd3, 16'd10);
        check("t1_dir_at_accept", {31'd0, dir}, 32'd1);
        check("t1_step_low_setup", {31'd0, step}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_ready_busy", {31'd0, move_ready}, 32'd0);
        wait_until(0, 1'b1, 20, n); check("t1_setup_cycles", n, 32'd4);
        check("t1_pos1", position, 32'd1);
        wait_until(0, 1'b0, 20, n); check("t1_high1", n, 32'd4);
        wait_until(0, 1'b1, 20, n); check("t1_low1", n, 32'd6);
        check("t1_pos2", position, 32'd2);
        wait_until(0, 1'b0, 20, n); check("t1_high2", n, 32'd4);
        wait_until(0, 1'b1, 20, n); check("t1_low2", n, 32'd6);
        check("t1_pos3", position, 32'd3);
        wait_until(0, 1'b0, 20, n); check("t1_high3", n, 32'd4);
        wait_until(1, 1'b1, 20, n); check("t1_done_delay", n, 32'd6);
        check("t1_busy_at_done", {31'd0, busy}, 32'd0);
        check("t1_aborted", {31'd0, aborted}, 32'd0);
        check("t1_ready_at_done", {31'd0, move_ready}, 32'd0);
        check("t1_step_at_done", {31'd0, step}, 32'd0);
        @(posedge clk); #1;
        check("t1_done_one_cycle", {31'd0, done}, 32'd0);
        check("t1_ready_after", {31'd0, move_ready}, 32'd1);

        // Reverse, same dir after reset: step the cycle after accept
        pulse_reset();
        issue(1'b0, 16'd2, 16'd20);
        check("t2_step_immediate", {31'd0, step}, 32'd1);
        check("t2_dir", {31'd0, dir}, 32'd0);
        check("t2_pos1", position, 32'hFFFF_FFFF);
        wait_until(0, 1'b0, 30, n); check("t2_high1", n, 32'd4);
        wait_until(0, 1'b1, 30, n); check("t2_low1", n, 32'd16);
        check("t2_pos2", position, 32'hFFFF_FFFE);
        check("t2_dir_mid", {31'd0, dir}, 32'd0);
        wait_until(0, 1'b0, 30, n); check("t2_high2", n, 32'd4);
        wait_until(1, 1'b1, 30, n); check("t2_done_delay", n, 32'd16);
        check("t2_dir_end", {31'd0, dir}, 32'd0);

        // Short period: period=1 -> spacing 2*PULSE_WIDTH
        pulse_reset();
        issue(1'b1, 16'd4, 16'd1);
        wait_until(0, 1'b1, 20, n); check("t3_setup", n, 32'd4);
        for (int i = 0; i < 3; i++) begin
            wait_until(0, 1'b0, 20, n); check("t3_high", n, 32'd4);
            wait_until(0, 1'b1, 20, n); check("t3_low", n, 32'd4);
        end
        wait_until(0, 1'b0, 20, n); check("t3_high_last", n, 32'd4);
        wait_until(1, 1'b1, 20, n); check("t3_done_delay", n, 32'd4);
        check("t3_pos", position, 32'd4);

        // Zero steps: done the cycle after accept, never busy
        @(posedge clk); #1;
        issue(1'b1, 16'd0, 16'd10);
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_aborted", {31'd0, aborted}, 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_step", {31'd0, step}, 32'd0);
        check("t4_ready", {31'd0, move_ready}, 32'd0);
        @(posedge clk); #1;
        check("t4_done_clear", {31'd0, done}, 32'd0);
        check("t4_pos", position, 32'd4);

        // Abort during third pulse's high phase
        issue(1'b1, 16'd100, 16'd50);
        check("t5_step_immediate", {31'd0, step}, 32'd1);
        wait_until(0, 1'b0, 60, n); check("t5_high1", n, 32'd4);
        wait_until(0, 1'b1, 60, n); check("t5_low1", n, 32'd46);
        wait_until(0, 1'b0, 60, n); check("t5_high2", n, 32'd4);
        wait_until(0, 1'b1, 60, n); check("t5_low2", n, 32'd46);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t5_no_runt", {31'd0, step}, 32'd1);
        wait_until(0, 1'b0, 20, n); check("t5_high3_rest", n, 32'd3);
        check("t5_pos", position, 32'd7);
        wait_until(1, 1'b1, 20, n); check("t5_abort_low", n, 32'd4);
        check("t5_aborted", {31'd0, aborted}, 32'd1);
        check("t5_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("t5_aborted_held", {31'd0, aborted}, 32'd1);

        // Abort during LOW: done the next cycle
        issue(1'b1, 16'd100, 16'd50);
        check("t5b_aborted_cleared", {31'd0, aborted}, 32'd0);
        wait_until(0, 1'b0, 20, n); check("t5b_high", n, 32'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t5b_done", {31'd0, done}, 32'd1);
        check("t5b_aborted", {31'd0, aborted}, 32'd1);
        check("t5b_busy", {31'd0, busy}, 32'd0);
        check("t5b_pos", position, 32'd8);
        @(posedge clk); #1;

        // Async reset mid-pulse, then a normal move
        issue(1'b1, 16'd5, 16'd10);
        check("t6_step_high", {31'd0, step}, 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("t6_rst_step", {31'd0, step}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_pos", position, 32'd0);
        check("t6_rst_ready", {31'd0, move_ready}, 32'd1);
        check("t6_rst_dir", {31'd0, dir}, 32'd0);
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        issue(1'b0, 16'd1, 16'd0);
        check("t6_step", {31'd0, step}, 32'd1);
        wait_until(0, 1'b0, 20, n); check("t6_high", n, 32'd4);
        wait_until(1, 1'b1, 20, n); check("t6_done_delay", n, 32'd4);
        check("t6_pos", position, 32'hFFFF_FFFF);
        check("t6_aborted", {31'd0, aborted}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
